// File: rtl/dpi_call_serializer_if.sv
// dpi_call_serializer_if
//   Bundles the request side and the shared-call observation side of
//   dpi_call_serializer.
//   master : request logic / testbench (drives req_valid, req_arg)
//   slave  : serializer (drives everything else)
//   Signals:
//     req_valid   [CHANNELS]        per-channel request
//     req_arg     [CHANNELS*ARG_W]  channel i at [i*ARG_W +: ARG_W]
//     req_ready   [CHANNELS]        combinational accept
//     call_active [CHANNELS]        registered active-call indicator
//     call_chan   [CH_W]            lowest active channel, 0 when idle
//     call_arg    [ARG_W]           captured argument of call_chan
//     rsp_valid   [CHANNELS]        one-cycle completion pulse
//     call_cnt    [CNT_W]           completed calls, saturating
//     failure_cnt [CNT_W]           collision cycles, saturating
interface dpi_call_serializer_if #(
  parameter int CHANNELS = 2,
  parameter int ARG_W    = 32,
  parameter int CNT_W    = 16
);
  localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic [CHANNELS-1:0]       req_valid;
  logic [CHANNELS*ARG_W-1:0] req_arg;
  logic [CHANNELS-1:0]       req_ready;
  logic [CHANNELS-1:0]       call_active;
  logic [CH_W-1:0]           call_chan;
  logic [ARG_W-1:0]          call_arg;
  logic [CHANNELS-1:0]       rsp_valid;
  logic [CNT_W-1:0]          call_cnt;
  logic [CNT_W-1:0]          failure_cnt;

  modport master (
    output req_valid, req_arg,
    input  req_ready, call_active, call_chan, call_arg, rsp_valid,
           call_cnt, failure_cnt
  );

  modport slave (
    input  req_valid, req_arg,
    output req_ready, call_active, call_chan, call_arg, rsp_valid,
           call_cnt, failure_cnt
  );
endinterface

// File: rtl/dpi_call_serializer.sv
// dpi_call_serializer
//   Funnels requests from CHANNELS independent callers onto one shared,
//   non-reentrant call resource. Round-robin arbitration, one call
//   outstanding, CALL_CYCLES cycles per call, one-cycle completion pulse.
//   A saturating collision counter records every cycle in which more than
//   one call is active.
//
//   Build option (macro DPI_SERIALIZE_EN):
//     defined   : single shared-resource FSM, round-robin grant.
//     undefined : concurrent mode, one independent FSM per channel
//                 (req_ready[i] = ~busy_i); overlaps show up in failure_cnt.
//
//   Ports:
//     clk     in  single clock, rising edge
//     rst_n   in  asynchronous active-low reset
//     io_bus  slave modport of dpi_call_serializer_if (see that file)
module dpi_call_serializer #(
  parameter int CHANNELS    = 2,
  parameter int ARG_W       = 32,
  parameter int CALL_CYCLES = 1,
  parameter int CNT_W       = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  dpi_call_serializer_if.slave io_bus
);
  localparam int CH_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int BL_W  = (CALL_CYCLES > 1) ? $clog2(CALL_CYCLES) : 1;
  localparam int SUM_W = CNT_W + $clog2(CHANNELS + 1) + 1;
  localparam logic [BL_W-1:0]  BL_LOAD = BL_W'(CALL_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CHANNELS-1:0] w_ready;
  logic [CHANNELS-1:0] w_done;    // calls completing at the coming edge
  logic [CHANNELS-1:0] w_active;
  logic [CHANNELS-1:0] w_rsp;
  logic [CH_W-1:0]     w_chan;
  logic [ARG_W-1:0]    w_arg;
  logic [CNT_W-1:0]    r_call_cnt;
  logic [CNT_W-1:0]    r_fail_cnt;
  logic [SUM_W-1:0]    w_call_sum;

`ifdef DPI_SERIALIZE_EN
  typedef enum logic {S_IDLE, S_BUSY} state_t;

  state_t              r_state;
  logic [CH_W-1:0]     r_last_grant;
  logic [CH_W-1:0]     r_chan;
  logic [BL_W-1:0]     r_busy_left;
  logic [ARG_W-1:0]    r_arg;
  logic [CHANNELS-1:0] r_active;
  logic [CHANNELS-1:0] r_rsp;
  logic                w_gnt_vld;
  logic [CH_W-1:0]     w_gnt;
  logic [CH_W-1:0]     w_idx;

  // Round-robin search starting one past the last grant, wrapping.
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt     = '0;
    w_idx     = '0;
    for (int k = 1; k <= CHANNELS; k++) begin
      w_idx = CH_W'((int'(r_last_grant) + k) % CHANNELS);
      if (!w_gnt_vld && io_bus.req_valid[w_idx]) begin
        w_gnt_vld = 1'b1;
        w_gnt     = w_idx;
      end
    end
  end

  // rst_n gating keeps ready low while reset is held even if callers
  // are already requesting.
  assign w_ready  = (rst_n && r_state == S_IDLE && w_gnt_vld) ?
                    (CHANNELS'(1) << w_gnt) : '0;
  assign w_done   = (r_state == S_BUSY && r_busy_left == '0) ? r_active : '0;
  assign w_active = r_active;
  assign w_rsp    = r_rsp;
  assign w_chan   = r_chan;
  assign w_arg    = r_arg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_last_grant <= CH_W'(CHANNELS - 1);   // channel 0 wins first
      r_chan       <= '0;
      r_busy_left  <= '0;
      r_arg        <= '0;
      r_active     <= '0;
      r_rsp        <= '0;
    end else begin
      r_rsp <= w_done;
      case (r_state)
        S_IDLE: begin
          if (w_gnt_vld) begin
            r_arg        <= io_bus.req_arg[int'(w_gnt)*ARG_W +: ARG_W];
            r_chan       <= w_gnt;
            r_last_grant <= w_gnt;
            r_busy_left  <= BL_LOAD;
            r_active     <= CHANNELS'(1) << w_gnt;
            r_state      <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (r_busy_left == '0) begin
            r_state  <= S_IDLE;
            r_active <= '0;
            r_chan   <= '0;
          end else begin
            r_busy_left <= r_busy_left - BL_W'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`else
  logic [CHANNELS-1:0][ARG_W-1:0] w_args;
  logic                           w_found;

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
    logic            r_busy;
    logic [BL_W-1:0] r_left;
    logic [ARG_W-1:0] r_arg;
    logic            r_rsp;

    assign w_ready[gi]  = rst_n & ~r_busy;
    assign w_done[gi]   = r_busy & (r_left == '0);
    assign w_active[gi] = r_busy;
    assign w_rsp[gi]    = r_rsp;
    assign w_args[gi]   = r_arg;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_busy <= 1'b0;
        r_left <= '0;
        r_arg  <= '0;
        r_rsp  <= 1'b0;
      end else begin
        r_rsp <= w_done[gi];
        if (io_bus.req_valid[gi] && w_ready[gi]) begin
          r_busy <= 1'b1;
          r_left <= BL_LOAD;
          r_arg  <= io_bus.req_arg[gi*ARG_W +: ARG_W];
        end else if (w_done[gi]) begin
          r_busy <= 1'b0;
        end else if (r_busy) begin
          r_left <= r_left - BL_W'(1);
        end
      end
    end
  end

  // Report the lowest-index active channel.
  always_comb begin
    w_chan  = '0;
    w_found = 1'b0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (!w_found && w_active[i]) begin
        w_found = 1'b1;
        w_chan  = CH_W'(i);
      end
    end
  end

  assign w_arg = w_args[w_chan];
`endif

  // Concurrent mode can retire several calls in one edge, so add the
  // completion count in a wider sum before saturating.
  assign w_call_sum = SUM_W'(r_call_cnt) + SUM_W'($countones(w_done));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_call_cnt <= '0;
      r_fail_cnt <= '0;
    end else begin
      r_call_cnt <= (w_call_sum > SUM_W'(CNT_MAX)) ? CNT_MAX
                                                   : w_call_sum[CNT_W-1:0];
      if ($countones(w_active) > 1 && r_fail_cnt != CNT_MAX)
        r_fail_cnt <= r_fail_cnt + CNT_W'(1);
    end
  end

  assign io_bus.req_ready   = w_ready;
  assign io_bus.call_active = w_active;
  assign io_bus.call_chan   = w_chan;
  assign io_bus.call_arg    = w_arg;
  assign io_bus.rsp_valid   = w_rsp;
  assign io_bus.call_cnt    = r_call_cnt;
  assign io_bus.failure_cnt = r_fail_cnt;
endmodule

// File: tb/tb_dpi_call_serializer.sv
module tb_dpi_call_serializer;
  localparam int CH   = 4;
  localparam int AW   = 32;
  localparam int CC   = 2;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

`ifdef DPI_SERIALIZE_EN
  localparam int PAIR_FAIL  = 0;  // ch0 then ch1, never overlapping
  localparam int DROP_CALLS = 1;  // ch3 request dropped while busy
`else
  localparam int PAIR_FAIL  = 2;  // both active for CC cycles
  localparam int DROP_CALLS = 2;  // ch3 runs alongside ch0
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc   = 0;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dpi_call_serializer_if #(.CHANNELS(CH), .ARG_W(AW), .CNT_W(CW)) bus();

  dpi_call_serializer #(
    .CHANNELS(CH), .ARG_W(AW), .CALL_CYCLES(CC), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .io_bus(bus)
  );

  typedef struct {
    int            ch;
    logic [AW-1:0] arg;
    int            cyc;
  } ev_t;

  ev_t act_q[$];   // expected call starts
  ev_t rsp_q[$];   // expected completion pulses

  // Reference model state
  logic [CH-1:0]         pend;
  logic [CH-1:0][AW-1:0] parg;
  int m_lg, m_free;
  int m_start[CH], m_end[CH], m_freei[CH];
  int e_calls, e_fail;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_lg   = CH - 1;
    m_free = 0;
    for (int i = 0; i < CH; i++) begin
      m_start[i] = -10; m_end[i] = -10; m_freei[i] = 0;
    end
    e_calls = 0;
    e_fail  = 0;
    pend    = '0;
    act_q.delete();
    rsp_q.delete();
  endtask

  // One cycle: drive pending requests at the negedge, predict handshakes.
  task automatic step();
    logic [CH-1:0] rdy, hs;
    int c, n;
    bit found;
    @(negedge clk);
    c = cyc;
    bus.req_valid = pend;
    for (int i = 0; i < CH; i++) bus.req_arg[i*AW +: AW] = parg[i];
    n = 0;
    for (int i = 0; i < CH; i++) begin
      if (c >= m_start[i] && c <= m_end[i]) n++;
      if (c == m_end[i] + 1 && e_calls < CMAX) e_calls++;
    end
    if (n > 1 && e_fail < CMAX) e_fail++;
    rdy = '0; hs = '0;
`ifdef DPI_SERIALIZE_EN
    found = 1'b0;
    if (c >= m_free) begin
      for (int k = 1; k <= CH; k++) begin
        int g;
        g = (m_lg + k) % CH;
        if (!found && pend[g]) begin
          found = 1'b1; rdy[g] = 1'b1; hs[g] = 1'b1;
          m_lg = g; m_free = c + CC + 1;
        end
      end
    end
`else
    found = 1'b0;
    for (int i = 0; i < CH; i++) begin
      if (c >= m_freei[i]) begin
        rdy[i] = 1'b1;
        if (pend[i]) begin hs[i] = 1'b1; m_freei[i] = c + CC + 1; found = 1'b1; end
      end
    end
`endif
    for (int i = 0; i < CH; i++) begin
      if (hs[i]) begin
        m_start[i] = c + 1;
        m_end[i]   = c + CC;
        act_q.push_back('{i, parg[i], c + 1});
        rsp_q.push_back('{i, '0, c + CC + 1});
        pend[i] = 1'b0;
      end
    end
    #1;
    chk("req_ready", bus.req_ready, rdy);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    bus.req_valid = '1;
    #1;
    chk("rst req_ready", bus.req_ready, 0);
    chk("rst call_active", bus.call_active, 0);
    chk("rst rsp_valid", bus.rsp_valid, 0);
    chk("rst call_chan", bus.call_chan, 0);
    chk("rst call_arg", bus.call_arg, 0);
    chk("rst call_cnt", bus.call_cnt, 0);
    chk("rst failure_cnt", bus.failure_cnt, 0);
    bus.req_valid = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  // Monitor: tracks expected activity windows and pops a response entry
  // for every rsp_valid bit the DUT presents.
  initial begin : mon
    int est[CH], een[CH];
    logic [AW-1:0] earg[CH];
    logic [CH-1:0] ea;
    int ech, c;
    bit fnd;
    ev_t ev;
    for (int i = 0; i < CH; i++) begin est[i] = -10; een[i] = -10; earg[i] = '0; end
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        for (int i = 0; i < CH; i++) begin est[i] = -10; een[i] = -10; end
      end else begin
        c = cyc;
        while (act_q.size() > 0 && act_q[0].cyc <= c) begin
          ev = act_q.pop_front();
          est[ev.ch] = ev.cyc; een[ev.ch] = ev.cyc + CC - 1; earg[ev.ch] = ev.arg;
        end
        ea = '0; ech = 0; fnd = 1'b0;
        for (int i = 0; i < CH; i++) begin
          if (c >= est[i] && c <= een[i]) begin
            ea[i] = 1'b1;
            if (!fnd) begin ech = i; fnd = 1'b1; end
          end
        end
        chk("call_active", bus.call_active, ea);
        chk("call_chan", bus.call_chan, ech);
        if (fnd) chk("call_arg", bus.call_arg, earg[ech]);
        for (int i = 0; i < CH; i++) begin
          if (bus.rsp_valid[i]) begin
            if (rsp_q.size() == 0) begin
              tests++; fails++;
              $display("FAIL rsp_unexpected: got rsp_valid[%0d]=1 expected none (cycle %0d)", i, c);
            end else begin
              ev = rsp_q.pop_front();
              chk("rsp_chan", i, ev.ch);
              chk("rsp_cycle", c, ev.cyc);
            end
          end
        end
        while (rsp_q.size() > 0 && rsp_q[0].cyc < c) begin
          ev = rsp_q.pop_front();
          tests++; fails++;
          $display("FAIL rsp_missing: got no rsp_valid[%0d] expected at cycle %0d", ev.ch, ev.cyc);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin : drv
    bus.req_valid = '0;
    bus.req_arg   = '0;
    parg          = '0;
    model_reset();

    // Reset values and idle hold
    do_reset();
    repeat (20) step();
    chk("idle failure_cnt", bus.failure_cnt, 0);
    chk("idle call_cnt", bus.call_cnt, 0);

    // Single call on channel 1
    parg[1] = 32'hA5A5_0001;
    pend    = 4'b0010;
    repeat (CC + 4) step();
    chk("single call_cnt", bus.call_cnt, 1);
    chk("single failure_cnt", bus.failure_cnt, 0);

    // All channels requesting continuously
    do_reset();
    for (int n = 0; n < 40; n++) begin
      pend = '1;
      for (int i = 0; i < CH; i++) parg[i] = {8'(i), 24'(n)};
      step();
    end
    pend = '0;
    repeat (CC + 3) step();
    chk("rr call_cnt", bus.call_cnt, e_calls);
    chk("rr failure_cnt", bus.failure_cnt, e_fail);

    // Two channels request in the same cycle
    do_reset();
    parg[0] = 32'h0000_1111;
    parg[1] = 32'h0000_2222;
    pend    = 4'b0011;
    repeat (2 * (CC + 1) + 3) step();
    chk("pair call_cnt", bus.call_cnt, 2);
    chk("pair failure_cnt", bus.failure_cnt, PAIR_FAIL);

    // Reset in the first active cycle of a call
    do_reset();
    parg[2] = 32'hDEAD_0002;
    pend    = 4'b0100;
    step();
    do_reset();
    repeat (CC + 3) step();
    chk("abort call_cnt", bus.call_cnt, 0);
    parg[0] = 32'h0000_00A0;
    parg[1] = 32'h0000_00A1;
    pend    = 4'b0011;
    repeat (2 * (CC + 1) + 3) step();
    chk("post-abort call_cnt", bus.call_cnt, 2);

    // Request withdrawn before it can be accepted (serialized: busy)
    do_reset();
    parg[0] = 32'h1234_5678;
    parg[3] = 32'h8765_4321;
    pend    = 4'b0001;
    step();
    pend[3] = 1'b1;
    step();
    pend = '0;
    repeat (CC + 4) step();
    chk("drop call_cnt", bus.call_cnt, DROP_CALLS);

    // Counter saturation: 20 back-to-back calls with a 4-bit counter
    do_reset();
    for (int n = 0; n < 20; n++) begin
      pend[n % CH] = 1'b1;
      parg[n % CH] = 32'hC000_0000 + 32'(n);
      for (int w = 0; w < CC + 3 && pend != '0; w++) step();
    end
    repeat (CC + 3) step();
    chk("sat call_cnt", bus.call_cnt, 15);
    chk("sat call_cnt model", bus.call_cnt, e_calls);
    chk("sat failure_cnt", bus.failure_cnt, e_fail);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/dpi_call_serializer.md
# dpi_call_serializer

Parametrised N-channel serializer that funnels requests from independent always-block "callers" onto one shared, non-reentrant call resource, such as a DPI import. Only one call is outstanding at a time. Access is arbitrated round-robin, and a saturating collision counter reports any cycle in which more than one call was active. It sits between per-channel request logic and the shared call port, and is the hardware-level check for DPI call serialization under multithreaded simulation.

## Interface
- `CHANNELS`, 2: number of requesting channels (≥2).
- `ARG_W`, 32: width of the call argument per channel.
- `CALL_CYCLES`, 1: cycles each call occupies the resource (≥1).
- `CNT_W`, 16: width of the statistics counters.
- `clk`  in  1  single clock; all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  CHANNELS  per-channel request.
- `req_arg`  in  CHANNELS*ARG_W  per-channel argument; channel i at [i*ARG_W +: ARG_W].
- `req_ready`  out  CHANNELS  handshake accept; combinational.
- `call_active`  out  CHANNELS  one-hot (serialized mode) active-call indicator; registered.
- `call_chan`  out  $clog2(CHANNELS)  index of lowest active channel; 0 when idle.
- `call_arg`  out  ARG_W  captured argument of `call_chan`.
- `rsp_valid`  out  CHANNELS  one-cycle completion pulse per channel; registered.
- `call_cnt`  out  CNT_W  completed calls, saturating.
- `failure_cnt`  out  CNT_W  collision cycles, saturating.

## Operation
- The FSM has two states per resource. IDLE has no call outstanding; BUSY has a call in progress, tracked by a down-counter `busy_left`.
- **IDLE:**
  - Search `req_valid` starting at `last_grant+1` and wrapping modulo CHANNELS.
  - The first set bit is grant g. `req_ready[g]` = 1 combinationally, and all other `req_ready` bits = 0.
  - A handshake is `req_valid[g] & req_ready[g]`.
  - On handshake: capture `req_arg[g]`, set `last_grant` = g, load `busy_left` = CALL_CYCLES−1, and go to BUSY.
- **BUSY:**
  - `call_active[g]` = 1 and `req_ready` = 0.
  - Decrement `busy_left` each cycle. When it is 0, go to IDLE and pulse `rsp_valid[g]` on the next cycle.
  - Increment `call_cnt` on that pulse, saturating at all-ones.
- **Arbitration fairness:** with all channels continuously requesting, grants rotate 0,1,…,CHANNELS−1,0.
- **Collision check:**
  - In any cycle where popcount(`call_active`) > 1, increment `failure_cnt`, saturating.
  - The count is 0 in serialized mode by construction; a non-zero value is a design failure.
- **Reset:**
  - All outputs and state return to their reset values immediately and asynchronously: `req_ready`/`call_active`/`rsp_valid` = 0, `call_chan` = 0, `call_arg` = 0, `call_cnt` = 0, `failure_cnt` = 0, `last_grant` = CHANNELS−1 so channel 0 wins first, and the state is IDLE.
  - A call in progress is aborted; no `rsp_valid` is produced for it.
- A `req_valid` deasserted before its handshake is dropped with no side effect.

## Timing
- A handshake in cycle T drives `call_active[g]` high in cycles T+1 … T+CALL_CYCLES.
- `rsp_valid[g]` pulses in cycle T+CALL_CYCLES+1, and the FSM is IDLE in that same cycle, so the next handshake may occur there.
- Throughput is one call per CALL_CYCLES+1 cycles.
- `call_chan`/`call_arg` are valid whenever `call_active` ≠ 0.
- `rsp_valid` and a new `req_ready` for the same channel may coincide. `last_grant` excludes that channel only if another channel is requesting.

## Configuration
- `DPI_SERIALIZE_EN` defined (default build): the single-resource FSM above applies.
- `DPI_SERIALIZE_EN` undefined, the concurrent mode matching "threads-dpi all":
  - Each channel has an independent FSM: `req_ready[i]` = ~busy_i, with the same latency.
  - Channels may be active simultaneously, and `failure_cnt` counts every overlapping cycle.
  - `call_chan`/`call_arg` report the lowest-index active channel.
  - The round-robin pointer is unused.

## Test plan
- **Reset values:** reset, then hold `req_valid`=0 → all outputs 0; `failure_cnt`=0 after 20 cycles.
- **Single call:** CALL_CYCLES=3, channel 1 requests `arg`=0xA5A5_0001 at T → `call_active`=2'b10 for T+1..T+3, `call_arg`=0xA5A5_0001, `rsp_valid[1]` at T+4, `call_cnt`=1.
- **Round-robin collision:** CHANNELS=4, all `req_valid` held high for 40 cycles with CALL_CYCLES=1 → grant order 0,1,2,3,0,…; `call_cnt`=20; `failure_cnt`=0.
- **Concurrent mode:** `DPI_SERIALIZE_EN` undefined, CHANNELS=2, both request at T with CALL_CYCLES=2 → both active T+1..T+2, `failure_cnt`=2.
- **Reset mid-call:** deassert `rst_n` during cycle T+1 of a CALL_CYCLES=4 call → `call_active`=0 immediately, no `rsp_valid`, `call_cnt`=0; a post-reset request is granted to channel 0.
- **Saturation:** CNT_W=4, 20 back-to-back calls → `call_cnt` holds at 15.
